// File: rtl/axil_fifo_write_drainer_if.sv
// Write-only AXI4-Lite channel bundle (AW, W, B) between the drainer and the interconnect.
// Latency: none, wires only.
// Backpressure: carried by the awready/wready valid-ready pairs and by bready for responses.
// Ports: master = drainer side (drives AW/W, accepts B); slave = interconnect side.
interface axil_fifo_write_drainer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output awaddr, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axil_fifo_write_drainer.sv
// Pops {addr,data,strb} entries from a show-ahead FIFO and issues one AXI4-Lite write per entry.
// Latency: pop -> AW/W valid next cycle; a zero-wait slave gives at least 4 cycles per entry.
// Backpressure: holds AW/W valid until accepted and waits for B; FIFO is popped only in IDLE.
// Ports: clk, resetn (sync, active-low), en, fifo_dout/fifo_empty/fifo_rd_en (FIFO read side),
//        m_axi (AXI-lite master), busy, wr_done, last_bresp, err_cnt, stall (status).
module axil_fifo_write_drainer #(
    parameter int  ADDR_W    = 32,
    parameter int  DATA_W    = 32,
    parameter int  ERR_CNT_W = 16,
    parameter int  STALL_CYC = 1024,
    localparam int STRB_W    = DATA_W / 8,
    localparam int ENTRY_W   = ADDR_W + DATA_W + STRB_W
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 en,
    input  logic [ENTRY_W-1:0]   fifo_dout,
    input  logic                 fifo_empty,
    output logic                 fifo_rd_en,
    axil_fifo_write_drainer_if.master m_axi,
    output logic                 busy,
    output logic                 wr_done,
    output logic [1:0]           last_bresp,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic                 stall
);
    localparam int WD_W = $clog2(STALL_CYC + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               state_q;
    logic [ADDR_W-1:0]    awaddr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [STRB_W-1:0]    wstrb_q;
    logic                 awvalid_q;
    logic                 wvalid_q;
    logic                 bready_q;
    logic                 busy_q;
    logic                 wr_done_q;
    logic [1:0]           last_bresp_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [WD_W-1:0]      wd_cnt_q;
    logic [WD_W-1:0]      wd_cnt_d;
    logic                 stall_q;
    logic                 aw_ok;
    logic                 w_ok;

    // The pop has to be a same-cycle pulse on a show-ahead FIFO, so it is decoded from state.
    // Holding off while wr_done is high gives the completion its own cycle before the next pop.
    assign fifo_rd_en = resetn && (state_q == IDLE) && en && !fifo_empty && !wr_done_q;

    // A channel is finished once its valid has dropped or is being accepted this cycle.
    assign aw_ok = !awvalid_q || m_axi.awready;
    assign w_ok  = !wvalid_q  || m_axi.wready;

    // Watchdog saturates at the threshold so it can never wrap back below it.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (wd_cnt_q != WD_W'(STALL_CYC)) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= IDLE;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            busy_q       <= 1'b0;
            wr_done_q    <= 1'b0;
            last_bresp_q <= 2'b00;
            err_cnt_q    <= '0;
            wd_cnt_q     <= '0;
            stall_q      <= 1'b0;
        end else begin
            wr_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (fifo_rd_en) begin
                        awaddr_q  <= fifo_dout[ENTRY_W-1 -: ADDR_W];
                        wdata_q   <= fifo_dout[STRB_W +: DATA_W];
                        wstrb_q   <= fifo_dout[STRB_W-1:0];
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        busy_q    <= 1'b1;
                        wd_cnt_q  <= '0;
                        stall_q   <= 1'b0;
                        state_q   <= SEND;
                    end
                end
                SEND: begin
                    wd_cnt_q <= wd_cnt_d;
                    stall_q  <= (wd_cnt_d >= WD_W'(STALL_CYC));
                    if (awvalid_q && m_axi.awready) begin
                        awvalid_q <= 1'b0;
                    end
                    if (wvalid_q && m_axi.wready) begin
                        wvalid_q <= 1'b0;
                    end
                    if (aw_ok && w_ok) begin
                        bready_q <= 1'b1;
                        state_q  <= RESP;
                    end
                end
                RESP: begin
                    // bready is always high here, so bvalid alone is the handshake.
                    if (m_axi.bvalid) begin
                        last_bresp_q <= m_axi.bresp;
                        if ((m_axi.bresp != 2'b00) && (err_cnt_q != '1)) begin
                            err_cnt_q <= err_cnt_q + 1'b1;
                        end
                        wr_done_q <= 1'b1;
                        bready_q  <= 1'b0;
                        busy_q    <= 1'b0;
                        wd_cnt_q  <= '0;
                        stall_q   <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        wd_cnt_q <= wd_cnt_d;
                        stall_q  <= (wd_cnt_d >= WD_W'(STALL_CYC));
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_axi.awaddr  = awaddr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;
    assign busy          = busy_q;
    assign wr_done       = wr_done_q;
    assign last_bresp    = last_bresp_q;
    assign err_cnt       = err_cnt_q;
    assign stall         = stall_q;
endmodule

// File: tb/tb_axil_fifo_write_drainer.sv
// Directed bench for axil_fifo_write_drainer: FIFO model, AXI-lite slave model, per-scenario tasks.
// Latency: n/a.
// Backpressure: slave model inserts programmable AW/W/B wait cycles.
module tb_axil_fifo_write_drainer;
    logic clk;
    logic resetn;
    logic en;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Show-ahead FIFO model: head is combinational from the read pointer.
    logic [67:0] fifo_mem [0:31];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic [67:0] fifo_dout;
    logic        fifo_empty;
    assign fifo_dout  = fifo_mem[rd_ptr[4:0]];
    assign fifo_empty = (rd_ptr == wr_ptr);

    logic        fifo_rd_en, busy, wr_done, stall;
    logic [1:0]  last_bresp;
    logic [15:0] err_cnt;
    logic        rd_en2, busy2, wr_done2, stall2;
    logic [1:0]  last_bresp2;
    logic [1:0]  err_cnt2;

    axil_fifo_write_drainer_if #(.ADDR_W(32), .DATA_W(32)) ifa ();
    axil_fifo_write_drainer_if #(.ADDR_W(32), .DATA_W(32)) ifb ();

    axil_fifo_write_drainer #(.ADDR_W(32), .DATA_W(32), .ERR_CNT_W(16), .STALL_CYC(8)) dut (
        .clk(clk), .resetn(resetn), .en(en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en), .m_axi(ifa.master), .busy(busy), .wr_done(wr_done),
        .last_bresp(last_bresp), .err_cnt(err_cnt), .stall(stall)
    );

    // Narrow-counter twin sees identical stimulus; used for saturation.
    axil_fifo_write_drainer #(.ADDR_W(32), .DATA_W(32), .ERR_CNT_W(2), .STALL_CYC(8)) dut2 (
        .clk(clk), .resetn(resetn), .en(en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_rd_en(rd_en2), .m_axi(ifb.master), .busy(busy2), .wr_done(wr_done2),
        .last_bresp(last_bresp2), .err_cnt(err_cnt2), .stall(stall2)
    );

    assign ifb.awready = ifa.awready;
    assign ifb.wready  = ifa.wready;
    assign ifb.bresp   = ifa.bresp;
    assign ifb.bvalid  = ifa.bvalid;

    // Slave model
    int         aw_delay = 0, w_delay = 0, b_delay = 0;
    int         aw_cnt, w_cnt, b_cnt;
    logic [1:0] resp_mem [0:31];
    int         b_hs = 0;

    initial begin
        ifa.awready = 1'b0; ifa.wready = 1'b0; ifa.bvalid = 1'b0; ifa.bresp = 2'b00;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        forever begin
            @(negedge clk);
            if (ifa.awvalid !== 1'b1) begin aw_cnt = 0; ifa.awready = 1'b0; end
            else if (aw_cnt >= aw_delay) ifa.awready = 1'b1;
            else aw_cnt++;
            if (ifa.wvalid !== 1'b1) begin w_cnt = 0; ifa.wready = 1'b0; end
            else if (w_cnt >= w_delay) ifa.wready = 1'b1;
            else w_cnt++;
            if (ifa.bready !== 1'b1) begin b_cnt = 0; ifa.bvalid = 1'b0; ifa.bresp = 2'b00; end
            else if (b_cnt >= b_delay) begin ifa.bvalid = 1'b1; ifa.bresp = resp_mem[b_hs[4:0]]; end
            else b_cnt++;
        end
    end

    // Monitor
    int          cyc = 0, done_cnt = 0, aw_cyc = 0, w_cyc = 0, stab_err = 0, rd_err = 0;
    int          aw_n = 0, w_n = 0;
    logic [31:0] aw_log [0:31];
    logic [35:0] w_log  [0:31];
    int          done_cyc [0:31];
    logic        prev_any = 1'b0;
    logic [67:0] prev_bus = '0;
    logic [67:0] cur_bus;
    logic        cur_any;

    always @(posedge clk) begin
        cyc++;
        if (fifo_rd_en === 1'b1) begin
            if (fifo_empty || busy) rd_err++;
            rd_ptr <= rd_ptr + 1;
        end
        if (ifa.awvalid === 1'b1) aw_cyc++;
        if (ifa.wvalid === 1'b1) w_cyc++;
        if (ifa.awvalid === 1'b1 && ifa.awready === 1'b1) begin aw_log[aw_n[4:0]] = ifa.awaddr; aw_n++; end
        if (ifa.wvalid === 1'b1 && ifa.wready === 1'b1) begin w_log[w_n[4:0]] = {ifa.wdata, ifa.wstrb}; w_n++; end
        if (ifa.bvalid === 1'b1 && ifa.bready === 1'b1) b_hs++;
        if (wr_done === 1'b1) begin done_cyc[done_cnt[4:0]] = cyc; done_cnt++; end
        cur_bus = {ifa.awaddr, ifa.wdata, ifa.wstrb};
        cur_any = (ifa.awvalid === 1'b1) || (ifa.wvalid === 1'b1);
        if (cur_any && prev_any && cur_bus !== prev_bus) stab_err++;
        prev_any = cur_any;
        prev_bus = cur_bus;
    end

    int tests = 0;
    int fails = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        fifo_mem[wr_ptr[4:0]] = {a, d, s};
        wr_ptr++;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        resetn = 1'b0; en = 1'b1;
        push(32'h0000_1000, 32'hDEAD_BEEF, 4'hF);
        tick(3);
        tests++; if (rd_ptr !== 0) begin fails++; $display("FAIL reset_pops: got %0d exp 0", rd_ptr); end
        tests++; if ({fifo_rd_en, rd_en2} !== 2'b00) begin fails++; $display("FAIL reset_rd_en: got %b exp 00", {fifo_rd_en, rd_en2}); end
        tests++; if ({ifa.awvalid, ifa.wvalid, ifa.bready} !== 3'b000) begin fails++; $display("FAIL reset_valids: got %b exp 000", {ifa.awvalid, ifa.wvalid, ifa.bready}); end
        tests++; if ({busy, wr_done, stall, last_bresp} !== 5'b0) begin fails++; $display("FAIL reset_status: got %b exp 00000", {busy, wr_done, stall, last_bresp}); end
        tests++; if ({err_cnt, err_cnt2} !== 18'h0) begin fails++; $display("FAIL reset_err_cnt: got %h exp 0", {err_cnt, err_cnt2}); end
        tests++; if ({ifa.awaddr, ifa.wdata, ifa.wstrb, ifa.awprot} !== 71'h0) begin fails++; $display("FAIL reset_bus: got %h exp 0", {ifa.awaddr, ifa.wdata, ifa.wstrb, ifa.awprot}); end
        en = 1'b0; resetn = 1'b1;
        tick(2);
        tests++; if (rd_ptr !== 0) begin fails++; $display("FAIL en_low_no_pop: got %0d exp 0", rd_ptr); end
    endtask

    task automatic test_single_write;
        int bd, bp, ba, bw;
        bd = done_cnt; bp = rd_ptr; ba = aw_n; bw = w_n;
        en = 1'b1;
        tick(1);
        tests++; if ({ifa.awvalid, ifa.wvalid, busy} !== 3'b111) begin fails++; $display("FAIL first_send_valids: got %b exp 111", {ifa.awvalid, ifa.wvalid, busy}); end
        wait_done(bd + 1, 50);
        tick(3);
        tests++; if (done_cnt - bd !== 1) begin fails++; $display("FAIL single_done: got %0d exp 1", done_cnt - bd); end
        tests++; if (aw_log[ba[4:0]] !== 32'h0000_1000) begin fails++; $display("FAIL single_awaddr: got %h exp 00001000", aw_log[ba[4:0]]); end
        tests++; if (w_log[bw[4:0]] !== {32'hDEAD_BEEF, 4'hF}) begin fails++; $display("FAIL single_wdata: got %h exp deadbeeff", w_log[bw[4:0]]); end
        tests++; if ({last_bresp, err_cnt} !== 18'h0) begin fails++; $display("FAIL single_resp: got %h exp 0", {last_bresp, err_cnt}); end
        tests++; if (rd_ptr - bp !== 1) begin fails++; $display("FAIL single_pops: got %0d exp 1", rd_ptr - bp); end
    endtask

    task automatic test_skewed;
        int bd, ba, bw, bac, bwc, bst, bb;
        bd = done_cnt; ba = aw_n; bw = w_n; bac = aw_cyc; bwc = w_cyc; bst = stab_err; bb = b_hs;
        aw_delay = 5;
        push(32'h2000_0004, 32'h1234_5678, 4'b0011);
        wait_done(bd + 1, 60);
        tick(2);
        aw_delay = 0;
        tests++; if (aw_cyc - bac !== 6) begin fails++; $display("FAIL skew_awvalid_cycles: got %0d exp 6", aw_cyc - bac); end
        tests++; if (w_cyc - bwc !== 1) begin fails++; $display("FAIL skew_wvalid_cycles: got %0d exp 1", w_cyc - bwc); end
        tests++; if (stab_err - bst !== 0) begin fails++; $display("FAIL skew_stability: got %0d exp 0", stab_err - bst); end
        tests++; if (b_hs - bb !== 1) begin fails++; $display("FAIL skew_b_count: got %0d exp 1", b_hs - bb); end
        tests++; if (aw_log[ba[4:0]] !== 32'h2000_0004) begin fails++; $display("FAIL skew_awaddr: got %h exp 20000004", aw_log[ba[4:0]]); end
        tests++; if (w_log[bw[4:0]] !== {32'h1234_5678, 4'b0011}) begin fails++; $display("FAIL skew_wdata: got %h exp 123456783", w_log[bw[4:0]]); end
    endtask

    task automatic test_errors;
        int bd, bb;
        bd = done_cnt; bb = b_hs;
        resp_mem[(bb + 0) % 32] = 2'b10;
        resp_mem[(bb + 1) % 32] = 2'b00;
        resp_mem[(bb + 2) % 32] = 2'b11;
        push(32'h0000_0100, 32'h1, 4'hF);
        push(32'h0000_0104, 32'h2, 4'hF);
        push(32'h0000_0108, 32'h3, 4'hF);
        wait_done(bd + 3, 80);
        tick(2);
        tests++; if (err_cnt !== 16'd2) begin fails++; $display("FAIL err_cnt_mixed: got %0d exp 2", err_cnt); end
        tests++; if (last_bresp !== 2'b11) begin fails++; $display("FAIL last_bresp_decerr: got %b exp 11", last_bresp); end
        tests++; if (err_cnt2 !== 2'd2) begin fails++; $display("FAIL err_cnt_narrow: got %0d exp 2", err_cnt2); end
        bb = b_hs;
        for (int i = 0; i < 3; i++) resp_mem[(bb + i) % 32] = 2'b10;
        push(32'h0000_0200, 32'h4, 4'hF);
        push(32'h0000_0204, 32'h5, 4'hF);
        push(32'h0000_0208, 32'h6, 4'hF);
        wait_done(bd + 6, 80);
        tick(2);
        tests++; if (err_cnt2 !== 2'd3) begin fails++; $display("FAIL err_cnt_saturate: got %0d exp 3", err_cnt2); end
        tests++; if (err_cnt !== 16'd5) begin fails++; $display("FAIL err_cnt_wide: got %0d exp 5", err_cnt); end
        tests++; if ({last_bresp, last_bresp2} !== 4'b1010) begin fails++; $display("FAIL last_bresp_slverr: got %b exp 1010", {last_bresp, last_bresp2}); end
    endtask

    task automatic test_stall;
        int bd, bp, k;
        bd = done_cnt; bp = rd_ptr;
        b_delay = 20;
        push(32'h0000_4000, 32'hAAAA_0000, 4'hF);
        push(32'h0000_4004, 32'hBBBB_0000, 4'hF);
        for (int i = 0; i < 20 && ifa.awvalid !== 1'b1; i++) tick(1);
        k = 0;
        while (stall !== 1'b1 && k < 40) begin tick(1); k++; end
        tests++; if (k !== 8) begin fails++; $display("FAIL stall_latency: got %0d exp 8", k); end
        tests++; if ({stall2, busy} !== 2'b11) begin fails++; $display("FAIL stall_twin_busy: got %b exp 11", {stall2, busy}); end
        tests++; if (rd_ptr - bp !== 1) begin fails++; $display("FAIL stall_no_second_pop: got %0d exp 1", rd_ptr - bp); end
        for (int i = 0; i < 60 && wr_done !== 1'b1; i++) tick(1);
        b_delay = 0;
        tests++; if ({wr_done, stall} !== 2'b10) begin fails++; $display("FAIL stall_clear_on_b: got %b exp 10", {wr_done, stall}); end
        wait_done(bd + 2, 40);
        tick(2);
        tests++; if ({done_cnt - bd, rd_ptr - bp} !== {32'd2, 32'd2}) begin fails++; $display("FAIL stall_drain: got %0d/%0d exp 2/2", done_cnt - bd, rd_ptr - bp); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL stall_after: got %b exp 0", stall); end
    endtask

    task automatic test_en_empty;
        int bd, bp, ba, bw;
        logic [31:0] ea;
        bd = done_cnt; bp = rd_ptr; ba = aw_n; bw = w_n;
        en = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h0000_3000 + 32'(4 * i), 32'hA0 + 32'(i), 4'hF);
        en = 1'b1;
        tick(1);
        en = 1'b0;
        wait_done(bd + 1, 40);
        tick(8);
        tests++; if ({done_cnt - bd, rd_ptr - bp} !== {32'd1, 32'd1}) begin fails++; $display("FAIL en_low_one_write: got %0d/%0d exp 1/1", done_cnt - bd, rd_ptr - bp); end
        tests++; if ({busy, fifo_rd_en, fifo_empty} !== 3'b000) begin fails++; $display("FAIL en_low_idle: got %b exp 000", {busy, fifo_rd_en, fifo_empty}); end
        en = 1'b1;
        wait_done(bd + 4, 80);
        tick(3);
        for (int i = 0; i < 4; i++) begin
            ea = 32'h0000_3000 + 32'(4 * i);
            tests++; if (aw_log[(ba + i) % 32] !== ea) begin fails++; $display("FAIL order_addr[%0d]: got %h exp %h", i, aw_log[(ba + i) % 32], ea); end
            tests++; if (w_log[(bw + i) % 32] !== {32'hA0 + 32'(i), 4'hF}) begin fails++; $display("FAIL order_data[%0d]: got %h exp %h", i, w_log[(bw + i) % 32], {32'hA0 + 32'(i), 4'hF}); end
        end
        tests++; if (done_cyc[(bd + 2) % 32] - done_cyc[(bd + 1) % 32] !== 4) begin fails++; $display("FAIL throughput_a: got %0d exp 4", done_cyc[(bd + 2) % 32] - done_cyc[(bd + 1) % 32]); end
        tests++; if (done_cyc[(bd + 3) % 32] - done_cyc[(bd + 2) % 32] !== 4) begin fails++; $display("FAIL throughput_b: got %0d exp 4", done_cyc[(bd + 3) % 32] - done_cyc[(bd + 2) % 32]); end
        tests++; if ({busy, fifo_rd_en, busy2, rd_en2} !== 4'b0000) begin fails++; $display("FAIL empty_idle: got %b exp 0000", {busy, fifo_rd_en, busy2, rd_en2}); end
        tests++; if (rd_ptr !== wr_ptr) begin fails++; $display("FAIL all_popped: got %0d exp %0d", rd_ptr, wr_ptr); end
        tests++; if ({rd_err, stab_err} !== {32'd0, 32'd0}) begin fails++; $display("FAIL protocol_errors: got %0d/%0d exp 0/0", rd_err, stab_err); end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin resp_mem[i] = 2'b00; fifo_mem[i] = '0; end
        test_reset();
        test_single_write();
        test_skewed();
        test_errors();
        test_stall();
        test_en_empty();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
